// File: rtl/slave_pkg.sv
// Shared definitions for the serial slave port: FSM state encoding,
// default geometry constants and a small sizing helper.
package slave_pkg;

  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_READ_DELAY = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RDELAY = 3'd4,
    ST_RDATA  = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_port_if.sv
// Bit-serial bus between a master and the slave port. The master drives
// the address/data/valid/write_en bits; the slave answers with ready and
// the serial read stream.
interface slave_port_if;

  logic address;
  logic data;
  logic valid;
  logic write_en;
  logic ready;
  logic data_out;
  logic valid_out;

  modport master (
    output address, data, valid, write_en,
    input  ready, data_out, valid_out
  );

  modport slave (
    input  address, data, valid, write_en,
    output ready, data_out, valid_out
  );

endinterface

// File: rtl/slave_memory.sv
// Word-addressed backing store: synchronous write, combinational read.
// Not reset, so contents survive a port reset.
module slave_memory
  import slave_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // write port, one word per enabled cycle
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/slave_port.sv
// Serial bus slave: collects an MSB-first address (and write word), then
// writes memory or, after a fixed busy delay, streams the stored word back.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for the first address bit; write_en latched here
// ST_ADDR   | shifting in the remaining address bits (gaps allowed)
// ST_WDATA  | shifting in the write word
// ST_WRITE  | single cycle that commits the word to memory
// ST_RDELAY | READ_DELAY+1 busy cycles; last one loads the read word
// ST_RDATA  | DATA_W cycles of valid_out with the word shifted out MSB first
module slave_port
  import slave_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int READ_DELAY = DEF_READ_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  slave_port_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W) + 1);
  localparam int DLY_W = $clog2(READ_DELAY + 2);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD  = DLY_W'(READ_DELAY);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rshift, w_rshift_nxt;
  logic              r_we, w_we_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [DLY_W-1:0]  r_dly_cnt, w_dly_cnt_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_valid_out, w_valid_out_nxt;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_rdata;

  // A reset landing on the WRITE cycle must not commit the word.
  slave_memory #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we && !reset),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  // next-state, datapath and registered-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_rshift_nxt  = r_rshift;
    w_we_nxt      = r_we;
    w_bit_cnt_nxt = r_bit_cnt;
    w_dly_cnt_nxt = r_dly_cnt;
    w_mem_we      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.valid) begin
          w_addr_nxt    = {{(ADDR_W-1){1'b0}}, bus.address};
          w_we_nxt      = bus.write_en;
          w_bit_cnt_nxt = CNT_W'(1);
          w_state_nxt   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.valid) begin
          w_addr_nxt = {r_addr[ADDR_W-2:0], bus.address};
          if (r_bit_cnt == ADDR_LAST) begin
            w_bit_cnt_nxt = '0;
            if (r_we) begin
              w_state_nxt = ST_WDATA;
            end else begin
              w_state_nxt   = ST_RDELAY;
              w_dly_cnt_nxt = DLY_LOAD;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_WDATA: begin
        if (bus.valid) begin
          w_wdata_nxt = {r_wdata[DATA_W-2:0], bus.data};
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = ST_WRITE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        w_mem_we    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_RDELAY: begin
        if (r_dly_cnt == '0) begin
          w_rshift_nxt = w_rdata;
          w_state_nxt  = ST_RDATA;
        end else begin
          w_dly_cnt_nxt = r_dly_cnt - 1'b1;
        end
      end
      ST_RDATA: begin
        // shifting in zeros leaves data_out low once the word is out
        w_rshift_nxt = r_rshift << 1;
        if (r_bit_cnt == DATA_LAST) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_ready_nxt     = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ADDR) ||
                      (w_state_nxt == ST_WDATA);
    w_valid_out_nxt = (w_state_nxt == ST_RDATA);
  end

  // state, counters, shift registers and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rshift    <= '0;
      r_we        <= 1'b0;
      r_bit_cnt   <= '0;
      r_dly_cnt   <= '0;
      r_ready     <= 1'b1;
      r_valid_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rshift    <= w_rshift_nxt;
      r_we        <= w_we_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_dly_cnt   <= w_dly_cnt_nxt;
      r_ready     <= w_ready_nxt;
      r_valid_out <= w_valid_out_nxt;
    end
  end

  assign bus.ready     = r_ready;
  assign bus.valid_out = r_valid_out;
  assign bus.data_out  = r_rshift[DATA_W-1];

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: two instances (READ_DELAY=2 and READ_DELAY=0).
// A transaction-level model predicts, per cycle, when the port is busy and
// which read bit must appear; literal expectations pin latency and data.
module tb_slave_port;

  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst     [2];
  logic a_addr  [2];
  logic a_data  [2];
  logic a_valid [2];
  logic a_we    [2];

  slave_port_if bus0 ();
  slave_port_if bus1 ();

  assign bus0.address  = a_addr[0];
  assign bus0.data     = a_data[0];
  assign bus0.valid    = a_valid[0];
  assign bus0.write_en = a_we[0];
  assign bus1.address  = a_addr[1];
  assign bus1.data     = a_data[1];
  assign bus1.valid    = a_valid[1];
  assign bus1.write_en = a_we[1];

  slave_port #(.ADDR_W(AW), .DATA_W(DW), .READ_DELAY(2)) dut0 (
    .clk(clk), .reset(rst[0]), .bus(bus0));
  slave_port #(.ADDR_W(AW), .DATA_W(DW), .READ_DELAY(0)) dut1 (
    .clk(clk), .reset(rst[1]), .bus(bus1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // model state: per-cycle exceptions to the idle outputs, and memory
  bit         exp_busy [int];
  bit         exp_vo   [int];
  bit         exp_bit  [int];
  logic [7:0] mem_model[int];

  function automatic int rd_delay(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 0) ? bus0.ready : bus1.ready;
  endfunction
  function automatic logic get_vo(input int d);
    return (d == 0) ? bus0.valid_out : bus1.valid_out;
  endfunction
  function automatic logic get_do(input int d);
    return (d == 0) ? bus0.data_out : bus1.data_out;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // per-cycle comparison of both ports against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int  k;
        bit  eb;
        bit  ev;
        bit  ed;
        k  = cyc * 2 + d;
        eb = exp_busy.exists(k);
        ev = exp_vo.exists(k);
        ed = exp_bit.exists(k) ? exp_bit[k] : 1'b0;
        check($sformatf("sb_ready%0d", d), {31'd0, get_ready(d)}, {31'd0, ~eb});
        check($sformatf("sb_valid_out%0d", d), {31'd0, get_vo(d)}, {31'd0, ev});
        check($sformatf("sb_data_out%0d", d), {31'd0, get_do(d)}, {31'd0, ed});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // present one bus bit once ready is seen; p = cycle it was presented
  task automatic send_bit(input int d, input logic ab, input logic db, input logic we,
                          output int p);
    int guard = 0;
    while (get_ready(d) !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("ready_wait", {31'd0, get_ready(d)}, 32'd1);
    a_valid[d] = 1'b1;
    a_addr[d]  = ab;
    a_data[d]  = db;
    a_we[d]    = we;
    p = cyc;
    step();
    a_valid[d] = 1'b0;
    a_addr[d]  = 1'b0;
    a_data[d]  = 1'b0;
    a_we[d]    = 1'b0;
  endtask

  // write_en is inverted after the first bit to show it is only sampled once
  task automatic send_addr(input int d, input logic [AW-1:0] addr, input logic we,
                           input int gap, output int p);
    for (int i = AW - 1; i >= 0; i--) begin
      send_bit(d, addr[i], 1'b0, (i == AW - 1) ? we : ~we, p);
      if (i > 0) idle(gap);
    end
  endtask

  task automatic do_write(input int d, input logic [AW-1:0] addr, input logic [DW-1:0] w);
    int p;
    send_addr(d, addr, 1'b1, 0, p);
    for (int i = DW - 1; i >= 0; i--) send_bit(d, 1'b0, w[i], 1'b0, p);
    exp_busy[(p + 1) * 2 + d] = 1'b1;
    mem_model[d * 65536 + int'(addr)] = w;
  endtask

  // write interrupted by reset after nbits data bits; valid held high
  // during the reset cycle, which must lose to reset
  task automatic do_write_abort(input int d, input logic [AW-1:0] addr,
                                input logic [DW-1:0] w, input int nbits);
    int p;
    send_addr(d, addr, 1'b1, 0, p);
    for (int i = DW - 1; i >= DW - nbits; i--) send_bit(d, 1'b0, w[i], 1'b0, p);
    rst[d]     = 1'b1;
    a_valid[d] = 1'b1;
    a_data[d]  = 1'b1;
    a_addr[d]  = 1'b1;
    step();
    rst[d]     = 1'b0;
    a_valid[d] = 1'b0;
    a_data[d]  = 1'b0;
    a_addr[d]  = 1'b0;
    check("abort_ready", {31'd0, get_ready(d)}, 32'd1);
  endtask

  task automatic do_read(input int d, input logic [AW-1:0] addr, input int gap,
                         input bit garbage, output logic [7:0] word,
                         output int first_vo, output int busy);
    int         p;
    int         rd;
    bit         done;
    logic [7:0] ew;
    send_addr(d, addr, 1'b0, gap, p);
    rd = rd_delay(d);
    ew = mem_model[d * 65536 + int'(addr)];
    for (int k = 1; k <= rd + 1 + DW; k++) exp_busy[(p + k) * 2 + d] = 1'b1;
    for (int j = 0; j < DW; j++) begin
      exp_vo[(p + rd + 2 + j) * 2 + d]  = 1'b1;
      exp_bit[(p + rd + 2 + j) * 2 + d] = ew[DW - 1 - j];
    end
    word = '0;
    first_vo = -1;
    busy = 0;
    done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (get_ready(d) === 1'b1) begin
        done = 1'b1;
        break;
      end
      busy++;
      if (get_vo(d) === 1'b1) begin
        if (first_vo < 0) first_vo = cyc - p;
        word = {word[6:0], get_do(d)};
      end
      if (garbage) begin
        a_valid[d] = 1'($urandom);
        a_addr[d]  = 1'($urandom);
        a_data[d]  = 1'($urandom);
        a_we[d]    = 1'($urandom);
      end
      step();
    end
    a_valid[d] = 1'b0;
    a_addr[d]  = 1'b0;
    a_data[d]  = 1'b0;
    a_we[d]    = 1'b0;
    check("read_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] w;
    int         fv;
    int         bz;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; a_addr[d] = 1'b0; a_data[d] = 1'b0; a_valid[d] = 1'b0; a_we[d] = 1'b0;
    end
    step();
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), {31'd0, get_ready(d)}, 32'd1);
      check($sformatf("rst_valid_out%0d", d), {31'd0, get_vo(d)}, 32'd0);
      check($sformatf("rst_data_out%0d", d), {31'd0, get_do(d)}, 32'd0);
    end
    idle(2);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    idle(2);

    // basic write then read
    do_write(0, 12'h123, 8'hA5);
    do_read(0, 12'h123, 0, 1'b0, w, fv, bz);
    check("rd_word", {24'd0, w}, 32'hA5);
    check("rd_first_vo", fv, 32'd4);
    check("rd_busy", bz, 32'd11);

    // gaps between address bits
    do_read(0, 12'h123, 3, 1'b0, w, fv, bz);
    check("gap_word", {24'd0, w}, 32'hA5);
    check("gap_first_vo", fv, 32'd4);
    check("gap_busy", bz, 32'd11);

    // reset mid-write: no commit, old word survives
    do_write_abort(0, 12'h123, 8'h5A, 4);
    idle(1);
    do_read(0, 12'h123, 0, 1'b0, w, fv, bz);
    check("abort_word", {24'd0, w}, 32'hA5);

    // address extremes stay distinct
    do_write(0, 12'hFFF, 8'h3C);
    do_write(0, 12'h000, 8'h00);
    do_read(0, 12'hFFF, 0, 1'b0, w, fv, bz);
    check("fff_word", {24'd0, w}, 32'h3C);
    do_read(0, 12'h000, 1, 1'b0, w, fv, bz);
    check("000_word", {24'd0, w}, 32'h00);

    // bus noise while busy is ignored; next transaction still works
    do_read(0, 12'h123, 0, 1'b1, w, fv, bz);
    check("noise_word", {24'd0, w}, 32'hA5);
    check("noise_busy", bz, 32'd11);
    do_write(0, 12'h055, 8'h77);
    do_read(0, 12'h055, 0, 1'b0, w, fv, bz);
    check("after_noise_word", {24'd0, w}, 32'h77);

    // zero read delay instance
    do_write(1, 12'h123, 8'hA5);
    do_read(1, 12'h123, 0, 1'b0, w, fv, bz);
    check("rd0_word", {24'd0, w}, 32'hA5);
    check("rd0_first_vo", fv, 32'd2);
    check("rd0_busy", bz, 32'd9);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
